// File: rtl/fifo_rr_drain_arb.sv
// fifo_rr_drain_arb
// Round-robin read scheduler. It drains NUM_SRC synchronous FIFOs into one
// valid/ready consumer stream. Each source is granted for a burst of up to
// BURST_LEN words before arbitration moves on.
//
// The FIFOs have registered read data: data_out updates on the edge where
// cs && rd_en && !empty. Each word therefore moves through three states:
// ISSUE pops the FIFO, LOAD captures fifo_data, and OUT presents the word
// until the consumer accepts it.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   src_en          per-source enable mask (0 removes a source from arbitration)
//   fifo_empty      combinational empty flags from the FIFOs
//   fifo_data       flattened FIFO data_out, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_cs         chip select, one-hot or zero
//   fifo_rd_en      read enable, identical to fifo_cs
//   m_valid/m_ready output handshake
//   m_data, m_src   output word and the index of the source it came from
//   busy            high whenever the scheduler is not idle
//
// Optional build macro FIFO_ARB_STATS_EN adds:
//   stat_clr        synchronous clear of the word counter (wins over increment)
//   stat_words      saturating 16-bit count of accepted output words
module fifo_rr_drain_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC-1:0]            fifo_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_SRC-1:0]            fifo_cs,
  output logic [NUM_SRC-1:0]            fifo_rd_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [SRC_W-1:0]              m_src,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [15:0]                   stat_words
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [SRC_W-1:0]      grant_q, grant_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SRC_W-1:0]      m_src_q, m_src_d;
  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    rd_sel;

  // Returns the first requester after 'base', wrapping modulo NUM_SRC.
  // The loop runs from the farthest candidate to the nearest, so the last
  // match it records is the nearest one.
  function automatic logic [SRC_W-1:0] pick_next(input logic [NUM_SRC-1:0] r,
                                                 input logic [SRC_W-1:0]   base);
    logic [SRC_W-1:0] sel;
    int idx;
    sel = base;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(base) + i) % NUM_SRC;
      if (r[idx]) sel = SRC_W'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_src_d      = m_src_q;
    rd_sel       = '0;
    req          = src_en & ~fifo_empty;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick_next(req, last_grant_q);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_sel[grant_q] = 1'b1;
        state_d         = S_LOAD;
      end
      S_LOAD: begin
        // The FIFO data_out was updated by the pop edge, so it is stable now.
        m_data_d  = fifo_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_src_d   = grant_q;
        m_valid_d = 1'b1;
        count_d   = count_q + CNT_W'(1);
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          // req is sampled after the pop, so a source drained by this burst
          // is not issued again.
          if (count_q < CNT_W'(BURST_LEN) && req[grant_q]) begin
            state_d = S_ISSUE;
          end else begin
            last_grant_d = grant_q;
            count_d      = '0;
            if (|req) begin
              grant_d = pick_next(req, grant_q);
              state_d = S_ISSUE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      count_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_src_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_src_q      <= m_src_d;
    end
  end

  assign fifo_cs    = rd_sel;
  assign fifo_rd_en = rd_sel;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_src      = m_src_q;
  assign busy       = (state_q != S_IDLE);

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_words_q, stat_words_d;

  always_comb begin
    stat_words_d = stat_words_q;
    if (stat_clr) begin
      stat_words_d = '0;
    end else if (m_valid_q && m_ready && stat_words_q != 16'hFFFF) begin
      stat_words_d = stat_words_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_words_q <= '0;
    else     stat_words_q <= stat_words_d;
  end

  assign stat_words = stat_words_q;
`endif

endmodule

// File: doc/fifo_rr_drain_arb.md
Name: fifo_rr_drain_arb

Overview:
- Round-robin read scheduler that drains NUM_SRC synchronous FIFOs into one valid/ready consumer stream.
- Each FIFO has one-cycle registered read data (data_out updates on the edge where cs && rd_en && !empty) and a combinational empty flag; this block drives each FIFO's cs/rd_en.
- Sits between the per-channel ingress FIFOs and the shared downstream datapath; grants in bursts of up to BURST_LEN words per source.

Parameters:
- NUM_SRC, 4, number of FIFOs drained (>=2); SRC_W = $clog2(NUM_SRC) as localparam
- DATA_WIDTH, 32, FIFO word width
- BURST_LEN, 4, max words popped from one source before re-arbitration (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src_en  in  NUM_SRC  per-source enable mask; 0 excludes a source from arbitration
- fifo_empty  in  NUM_SRC  empty flags from the FIFOs
- fifo_data  in  NUM_SRC*DATA_WIDTH  flattened FIFO data_out, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_cs  out  NUM_SRC  chip select, one-hot or zero
- fifo_rd_en  out  NUM_SRC  read enable, equal to fifo_cs
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts when m_valid && m_ready
- m_data  out  DATA_WIDTH  output word
- m_src  out  SRC_W  source index of m_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, m_valid 0, m_data 0, m_src 0, grant 0, last_grant NUM_SRC-1 (source 0 has first priority), burst count 0; fifo_cs/fifo_rd_en 0 combinationally; busy 0.
- req[i] = src_en[i] && !fifo_empty[i]. Next grant = first set req starting at last_grant+1, wrapping modulo NUM_SRC.
- IDLE: if any req, latch grant, go ISSUE; else stay.
- ISSUE (exactly 1 cycle): fifo_cs[grant] = fifo_rd_en[grant] = 1, all others 0; go LOAD.
- LOAD (1 cycle): at end of cycle register m_data <= fifo_data[grant], m_src <= grant, m_valid <= 1, count <= count+1; go OUT.
- OUT: hold m_valid/m_data/m_src stable until m_ready. On accept: m_valid <= 0; if count < BURST_LEN and req[grant], go ISSUE with same grant; else last_grant <= grant, count <= 0, and if any req pick new grant and go ISSUE, else go IDLE.
- Latency: req seen in IDLE at cycle 0 -> rd_en at cycle 1 -> m_valid at cycle 3. Sustained max throughput 1 word / 3 cycles with m_ready tied high.
- fifo_rd_en only asserted when req[grant] was true at the decision point, so never pops an empty FIFO; at most one rd_en high per cycle.
- src_en deasserted for the granted source mid-burst: current word still delivered; burst ends at next accept.
- Only one source requesting: it is re-granted repeatedly; burst counter still resets every BURST_LEN words.
- m_ready held low: stall in OUT indefinitely, no further FIFO reads.
- Reset asserted mid-operation: all state returns to reset values immediately; a word already popped but not accepted is dropped.

Optional Feature:
- Macro FIFO_ARB_STATS_EN. When defined: extra output stat_words (16 bits), reset 0, increments on every m_valid && m_ready, saturates at 16'hFFFF; extra input stat_clr (1 bit), synchronous clear, priority over increment in the same cycle. When undefined: both ports and the counter are absent; all other behaviour unchanged.

Test Plan:
- Reset release, all FIFOs empty for 10 cycles -> fifo_rd_en stays 0, m_valid 0, busy 0, state IDLE.
- Source 2 holds 3 words A,B,C, others empty, m_ready=1 -> rd_en[2] pulses at cycles 1,4,7; m_data A,B,C with m_src=2, m_valid at cycles 3,6,9.
- All 4 sources hold 6 words, BURST_LEN=4, m_ready=1 -> m_src order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,1,1,2,2,3,3.
- m_ready low for 20 cycles while m_valid=1 -> m_data/m_src stable, no rd_en pulses; after m_ready=1 sequence resumes with no loss or duplication.
- src_en=4'b1010 with all FIFOs non-empty -> only sources 1 and 3 ever granted, alternating per burst.
- Assert rst during LOAD of source 1 -> outputs return to reset values same cycle; after release, arbitration restarts with source 0 priority. With FIFO_ARB_STATS_EN: 5 accepted words -> stat_words=5; stat_clr pulse -> 0.
